// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - program counter and next-PC selection for the single-cycle datapath
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [5:0]  HALT_OPCODE = 6'b111111,
    parameter int          CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 branch_taken,
    input  logic                 jump,
    input  logic [31:0]          instruction,
    output logic [31:0]          pc,
    output logic [31:0]          pc_plus4,
    output logic                 valid,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] fetch_count
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t               state_q;
    state_t               state_next;
    logic [31:0]          pc_q;
    logic [31:0]          pc_next;
    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] count_next;
    logic                 count_inc;
    logic [31:0]          jump_target;
    logic [31:0]          branch_target;
    logic                 is_halt_op;

    assign pc_plus4      = pc_q + 32'd4;
    assign jump_target   = {pc_plus4[31:28], instruction[25:0], 2'b00};
    assign branch_target = pc_plus4 + {{14{instruction[15]}}, instruction[15:0], 2'b00};
    assign is_halt_op    = (instruction[31:26] == HALT_OPCODE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            count_q <= '0;
        end else begin
            state_q <= state_next;
            pc_q    <= pc_next;
            count_q <= count_next;
        end
    end

    // Rules in RUN are evaluated in priority order: halt, stall, jump, branch, sequential.
    always_comb begin
        state_next = state_q;
        pc_next    = pc_q;
        count_inc  = 1'b0;
        case (state_q)
            BOOT: state_next = RUN;
            RUN: begin
                if (is_halt_op && !stall) begin
                    state_next = HALT;
                    count_inc  = 1'b1;
                end else if (stall) begin
                    count_inc = 1'b0;
                end else if (jump) begin
                    pc_next   = jump_target;
                    count_inc = 1'b1;
                end else if (branch_taken) begin
                    pc_next   = branch_target;
                    count_inc = 1'b1;
                end else begin
                    pc_next   = pc_plus4;
                    count_inc = 1'b1;
                end
            end
            HALT:    state_next = HALT;
            default: state_next = BOOT;
        endcase
    end

    // Retired-fetch counter saturates rather than wrapping.
    always_comb begin
        count_next = count_q;
        if (count_inc && (count_q != {CNT_WIDTH{1'b1}})) begin
            count_next = count_q + CNT_WIDTH'(1);
        end
    end

    assign pc          = pc_q;
    assign valid       = (state_q == RUN);
    assign halted      = (state_q == HALT);
    assign fetch_count = count_q;

endmodule
